// File: rtl/dense_out10_pkg.sv
// Shared constants and FSM state type for the dense_out10 output layer.
package dense_out10_pkg;

  localparam int N_OUT = 10;

  typedef enum logic [2:0] {
    IDLE,
    BIAS,
    MAC,
    LAST,
    STORE,
    OUT
  } dense_state_t;

endpackage

// File: rtl/dense_out10_acc_requant.sv
// Combinational requantiser: arithmetic right shift and saturation from ACC_W to WIDTH.
// Optional round-half-up offset when DENSE_OUT10_ROUND_EN is defined.
module acc_requant #(
  parameter int ACC_W = 24,
  parameter int WIDTH = 8,
  parameter int SHIFT = 4
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [WIDTH-1:0] q
);

  // One extra bit so the rounding offset can never wrap the accumulator value.
  localparam int EW = ACC_W + 1;
  localparam logic signed [EW-1:0] Q_MAX = EW'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [EW-1:0] Q_MIN = ~Q_MAX;
`ifdef DENSE_OUT10_ROUND_EN
  localparam logic signed [EW-1:0] RND = (SHIFT > 0) ? (EW'(1) <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
`else
  localparam logic signed [EW-1:0] RND = '0;
`endif

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] shifted;

  always_comb begin
    ext     = EW'(acc) + RND;
    shifted = ext >>> SHIFT;
    if (shifted > Q_MAX) begin
      q = Q_MAX[WIDTH-1:0];
    end else if (shifted < Q_MIN) begin
      q = Q_MIN[WIDTH-1:0];
    end else begin
      q = shifted[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/dense_out10.sv
// Time-multiplexed 10-class output layer: one MAC, weights/biases from a 1-cycle ROM.
// Rounding on requantisation is enabled with DENSE_OUT10_ROUND_EN.
module dense_out10
  import dense_out10_pkg::*;
#(
  parameter int N_IN   = 16,
  parameter int IN_W   = 8,
  parameter int W_W    = 8,
  parameter int WIDTH  = 8,
  parameter int ACC_W  = 24,
  parameter int SHIFT  = 4,
  parameter int ADDR_W = $clog2(N_OUT * N_IN + N_OUT)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  x [N_IN],
  output logic                    w_en,
  output logic [ADDR_W-1:0]       w_addr,
  input  logic signed [W_W-1:0]   w_data,
  output logic signed [WIDTH-1:0] scores [N_OUT],
  output logic                    start
);

  localparam int I_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int J_W = $clog2(N_OUT);
  localparam int P_W = IN_W + W_W;

  dense_state_t            state_q, state_d;
  logic [J_W-1:0]          j_q, j_d;
  logic [I_W-1:0]          i_q, i_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [IN_W-1:0]  x_q [N_IN];
  logic signed [IN_W-1:0]  x_d [N_IN];
  logic signed [WIDTH-1:0] scores_q [N_OUT];
  logic signed [WIDTH-1:0] scores_d [N_OUT];
  logic signed [IN_W-1:0]  mac_x;
  logic signed [P_W-1:0]   prod;
  logic signed [WIDTH-1:0] requant;

  acc_requant #(
    .ACC_W (ACC_W),
    .WIDTH (WIDTH),
    .SHIFT (SHIFT)
  ) u_requant (
    .acc (acc_q),
    .q   (requant)
  );

  assign scores = scores_q;

  always_comb begin
    state_d  = state_q;
    j_d      = j_q;
    i_d      = i_q;
    acc_d    = acc_q;
    x_d      = x_q;
    scores_d = scores_q;
    in_ready = 1'b0;
    start    = 1'b0;
    w_en     = 1'b0;
    w_addr   = '0;
    mac_x    = x_q[N_IN-1];
    // ROM data lags the address by one cycle, so each MAC cycle uses the previous feature.
    if (state_q == MAC && i_q != '0) begin
      mac_x = x_q[i_q - 1'b1];
    end
    prod = P_W'(w_data) * P_W'(mac_x);

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          x_d     = x;
          j_d     = '0;
          state_d = BIAS;
        end
      end
      BIAS: begin
        w_en    = 1'b1;
        w_addr  = ADDR_W'(N_OUT * N_IN + int'(j_q));
        i_d     = '0;
        state_d = MAC;
      end
      MAC: begin
        w_en   = 1'b1;
        w_addr = ADDR_W'(int'(j_q) * N_IN + int'(i_q));
        if (i_q == '0) begin
          acc_d = ACC_W'(w_data) <<< SHIFT;
        end else begin
          acc_d = acc_q + ACC_W'(prod);
        end
        if (i_q == I_W'(N_IN - 1)) begin
          state_d = LAST;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      LAST: begin
        acc_d   = acc_q + ACC_W'(prod);
        state_d = STORE;
      end
      STORE: begin
        scores_d[j_q] = requant;
        if (j_q == J_W'(N_OUT - 1)) begin
          state_d = OUT;
        end else begin
          j_d     = j_q + 1'b1;
          state_d = BIAS;
        end
      end
      OUT: begin
        start   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      j_q      <= '0;
      i_q      <= '0;
      acc_q    <= '0;
      x_q      <= '{default: '0};
      scores_q <= '{default: '0};
    end else begin
      state_q  <= state_d;
      j_q      <= j_d;
      i_q      <= i_d;
      acc_q    <= acc_d;
      x_q      <= x_d;
      scores_q <= scores_d;
    end
  end

endmodule

// File: tb/tb_dense_out10.sv
// Self-checking bench for dense_out10 (N_IN=4, SHIFT=4) with a behavioural ROM and score model.
module tb_dense_out10;

  localparam int N_IN   = 4;
  localparam int IN_W   = 8;
  localparam int W_W    = 8;
  localparam int WIDTH  = 8;
  localparam int ACC_W  = 24;
  localparam int SHIFT  = 4;
  localparam int N_OUT  = 10;
  localparam int ROM_N  = N_OUT * N_IN + N_OUT;
  localparam int ADDR_W = $clog2(ROM_N);
  localparam int RUN_CYC = N_OUT * (N_IN + 3) + 1;
`ifdef DENSE_OUT10_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  typedef struct {
    int x0, x1, x2, x3;
    int w;
    int b;
    int exp_t;
    int exp_r;
  } vec_t;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic signed [IN_W-1:0]  x [N_IN];
  logic                    w_en;
  logic [ADDR_W-1:0]       w_addr;
  logic signed [W_W-1:0]   w_data = '0;
  logic signed [WIDTH-1:0] scores [N_OUT];
  logic                    start;

  int rom [ROM_N];
  int errors = 0;
  int checks = 0;

  dense_out10 #(
    .N_IN  (N_IN),
    .IN_W  (IN_W),
    .W_W   (W_W),
    .WIDTH (WIDTH),
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .w_en     (w_en),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .scores   (scores),
    .start    (start)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (w_en) w_data <= (int'(w_addr) < ROM_N) ? W_W'(rom[w_addr]) : '0;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int floor_div(input int a, input int d);
    int q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Reference: score = clamp(floor((b*2^S + sum w*x [+ 2^(S-1)]) / 2^S))
  function automatic int model_score(input int j, input int xv[N_IN]);
    int d, a, q, hi, lo;
    d  = 1 << SHIFT;
    hi = (1 << (WIDTH - 1)) - 1;
    lo = -(1 << (WIDTH - 1));
    a  = rom[N_OUT * N_IN + j] * d;
    for (int i = 0; i < N_IN; i++) a += rom[j * N_IN + i] * xv[i];
    if (ROUND && SHIFT > 0) a += d / 2;
    q = floor_div(a, d);
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return q;
  endfunction

  task automatic fill_uniform(input int w, input int b);
    for (int a = 0; a < N_OUT * N_IN; a++) rom[a] = w;
    for (int j = 0; j < N_OUT; j++) rom[N_OUT * N_IN + j] = b;
  endtask

  task automatic fill_random();
    for (int a = 0; a < ROM_N; a++) rom[a] = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic fill_scen1();
    fill_uniform(0, 0);
    for (int j = 0; j < N_OUT; j++) begin
      rom[j * N_IN] = 1;
      rom[N_OUT * N_IN + j] = j;
    end
  endtask

  task automatic run_vec(input int xv[N_IN], output int scyc, output int pulses,
                         output int rdy_busy, output int rdy_next, output int sc[N_OUT]);
    @(negedge clk);
    for (int i = 0; i < N_IN; i++) x[i] = IN_W'(xv[i]);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    scyc = -1; pulses = 0; rdy_busy = 0; rdy_next = 0;
    for (int j = 0; j < N_OUT; j++) sc[j] = 0;
    for (int n = 1; n <= RUN_CYC + 30; n++) begin
      @(negedge clk);
      if (scyc > 0 && n == scyc + 1) rdy_next = int'(in_ready);
      if (start) begin
        pulses++;
        if (scyc < 0) begin
          scyc = n;
          for (int j = 0; j < N_OUT; j++) sc[j] = int'(scores[j]);
        end
      end
      if (in_ready && (scyc < 0 || n <= scyc)) rdy_busy++;
    end
  endtask

  task automatic check_run(input string tag, input int scyc, input int pulses,
                           input int rdy_busy, input int rdy_next);
    check({tag, "_start_cycle"}, scyc, RUN_CYC);
    check({tag, "_pulses"}, pulses, 1);
    check({tag, "_ready_busy"}, rdy_busy, 0);
    check({tag, "_ready_after"}, rdy_next, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_timeout"}, int'(in_ready), 1);
  endtask

  initial begin
    vec_t tbl[10];
    int   xv[N_IN];
    int   xv2[N_IN];
    int   sc[N_OUT];
    int   sc2[N_OUT];
    int   scyc, pulses, rdy_busy, rdy_next, s1, s2, nz, idx, e;

    tbl[0] = '{x0: 127,  x1: 127,  x2: 127, x3: 127,  w: 127,  b: 0,    exp_t: 127,  exp_r: 127};
    tbl[1] = '{x0: 127,  x1: 127,  x2: 127, x3: 127,  w: -128, b: 0,    exp_t: -128, exp_r: -128};
    tbl[2] = '{x0: 10,   x1: 0,    x2: 0,   x3: 0,    w: 4,    b: 0,    exp_t: 2,    exp_r: 3};
    tbl[3] = '{x0: -10,  x1: 0,    x2: 0,   x3: 0,    w: 4,    b: 0,    exp_t: -3,   exp_r: -2};
    tbl[4] = '{x0: 1,    x1: 2,    x2: 3,   x3: 4,    w: 2,    b: 1,    exp_t: 2,    exp_r: 2};
    tbl[5] = '{x0: 0,    x1: 0,    x2: 0,   x3: 0,    w: 5,    b: -3,   exp_t: -3,   exp_r: -3};
    tbl[6] = '{x0: 16,   x1: -16,  x2: 32,  x3: 0,    w: 1,    b: 0,    exp_t: 2,    exp_r: 2};
    tbl[7] = '{x0: 0,    x1: 0,    x2: 0,   x3: 0,    w: 0,    b: 127,  exp_t: 127,  exp_r: 127};
    tbl[8] = '{x0: 0,    x1: 0,    x2: 0,   x3: 0,    w: 0,    b: -128, exp_t: -128, exp_r: -128};
    tbl[9] = '{x0: -128, x1: -128, x2: -128, x3: -128, w: -128, b: 0,   exp_t: 127,  exp_r: 127};

    for (int i = 0; i < N_IN; i++) x[i] = '0;
    fill_uniform(0, 0);

    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_start", int'(start), 0);
    check("rst_w_en", int'(w_en), 0);
    check("rst_w_addr", int'(w_addr), 0);
    nz = 0;
    for (int j = 0; j < N_OUT; j++) if (scores[j] != '0) nz++;
    check("rst_scores_nonzero", nz, 0);
    reset_n = 1'b1;

    for (int k = 0; k < 10; k++) begin
      fill_uniform(tbl[k].w, tbl[k].b);
      xv[0] = tbl[k].x0; xv[1] = tbl[k].x1; xv[2] = tbl[k].x2; xv[3] = tbl[k].x3;
      run_vec(xv, scyc, pulses, rdy_busy, rdy_next, sc);
      check_run($sformatf("tbl%0d", k), scyc, pulses, rdy_busy, rdy_next);
      e = ROUND ? tbl[k].exp_r : tbl[k].exp_t;
      for (int j = 0; j < N_OUT; j++) check($sformatf("tbl%0d_s%0d", k, j), sc[j], e);
    end

    fill_scen1();
    xv = '{3, 0, 0, 0};
    run_vec(xv, scyc, pulses, rdy_busy, rdy_next, sc);
    check_run("scen1", scyc, pulses, rdy_busy, rdy_next);
    for (int j = 0; j < N_OUT; j++) check($sformatf("scen1_s%0d", j), sc[j], j);

    for (int r = 0; r < 6; r++) begin
      fill_random();
      for (int i = 0; i < N_IN; i++) xv[i] = int'($urandom_range(0, 255)) - 128;
      run_vec(xv, scyc, pulses, rdy_busy, rdy_next, sc);
      check_run($sformatf("rnd%0d", r), scyc, pulses, rdy_busy, rdy_next);
      for (int j = 0; j < N_OUT; j++) check($sformatf("rnd%0d_s%0d", r, j), sc[j], model_score(j, xv));
    end

    // in_valid held high, x scrambled every cycle while busy
    fill_random();
    @(negedge clk);
    for (int i = 0; i < N_IN; i++) begin
      xv[i] = int'($urandom_range(0, 255)) - 128;
      x[i]  = IN_W'(xv[i]);
    end
    xv2 = xv;
    in_valid = 1'b1;
    pulses = 0; s1 = -1; s2 = -1;
    for (int j = 0; j < N_OUT; j++) begin sc[j] = 0; sc2[j] = 0; end
    for (int n = 1; n <= 2 * RUN_CYC + 27; n++) begin
      @(negedge clk);
      if (start) begin
        pulses++;
        if (s1 < 0) begin
          s1 = n;
          for (int j = 0; j < N_OUT; j++) sc[j] = int'(scores[j]);
        end else if (s2 < 0) begin
          s2 = n;
          for (int j = 0; j < N_OUT; j++) sc2[j] = int'(scores[j]);
        end
      end
      for (int i = 0; i < N_IN; i++) x[i] = IN_W'($urandom_range(0, 255));
      if (n == RUN_CYC + 1) for (int i = 0; i < N_IN; i++) xv2[i] = int'(x[i]);
    end
    in_valid = 1'b0;
    check("b2b_first_start", s1, RUN_CYC);
    check("b2b_second_start", s2, 2 * RUN_CYC + 1);
    check("b2b_pulses", pulses, 2);
    for (int j = 0; j < N_OUT; j++) check($sformatf("b2b_a_s%0d", j), sc[j], model_score(j, xv));
    for (int j = 0; j < N_OUT; j++) check($sformatf("b2b_b_s%0d", j), sc2[j], model_score(j, xv2));
    wait_idle("b2b");

    // reset asserted partway through a run
    fill_scen1();
    @(negedge clk);
    x[0] = 8'sd3; x[1] = '0; x[2] = '0; x[3] = '0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (30) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_start", int'(start), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_w_en", int'(w_en), 0);
    nz = 0;
    for (int j = 0; j < N_OUT; j++) if (scores[j] != '0) nz++;
    check("midrst_scores_nonzero", nz, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    pulses = 0; rdy_busy = 0;
    for (int n = 0; n < RUN_CYC + 20; n++) begin
      @(negedge clk);
      if (start) pulses++;
      if (!in_ready) rdy_busy++;
    end
    check("midrst_pulses", pulses, 0);
    check("midrst_not_ready_cycles", rdy_busy, 0);
    xv = '{3, 0, 0, 0};
    run_vec(xv, scyc, pulses, rdy_busy, rdy_next, sc);
    check_run("postrst", scyc, pulses, rdy_busy, rdy_next);
    for (int j = 0; j < N_OUT; j++) check($sformatf("postrst_s%0d", j), sc[j], j);

    // downstream argmax view of the scores sampled at start
    fill_uniform(0, 0);
    rom[N_OUT * N_IN + 7] = 100;
    for (int i = 0; i < N_IN; i++) xv[i] = int'($urandom_range(0, 255)) - 128;
    run_vec(xv, scyc, pulses, rdy_busy, rdy_next, sc);
    check_run("argmax", scyc, pulses, rdy_busy, rdy_next);
    idx = 0;
    for (int j = 1; j < N_OUT; j++) if (sc[j] > sc[idx]) idx = j;
    check("argmax_idx", idx, 7);
    check("argmax_val", sc[7], 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
